// File: rtl/alu_datapath.sv
// Add/sub, Booth multiply and restoring divide datapath.
// Registers A, Q, M, Q_1 and a step counter, driven by ALU_CU strobes.
module alu_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] INBUS,
    input  logic             c0,
    input  logic             c0_prim,
    input  logic             c1,
    input  logic             c2,
    input  logic             c3,
    input  logic             c4,
    input  logic             c7_5,
    input  logic             cR,
    input  logic             cL,
    input  logic             c5,
    input  logic             c6,
    input  logic             c7,
    input  logic             c8,
    output logic             Q0,
    output logic             Q_1,
    output logic             A7,
    output logic             CNT7,
    output logic [WIDTH-1:0] OUTBUS,
    output logic             OVF,
    output logic             DONE
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] cnt_q;

    logic             arith_en;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a_arith;
    logic             ovf_next;
    logic             shift_en;
    logic             shr;
    logic             shl;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] q_next;
    logic             q1_next;
    logic [CNT_W-1:0] cnt_next;

    // Subtract has priority over add when both are strobed
    always_comb begin
        arith_en = c3 | c4 | c7_5;
        op_b     = c4 ? (~m_q + ONE) : m_q;
        sum      = a_q + op_b;
        a_arith  = arith_en ? sum : a_q;
        ovf_next = (a_q[MSB] == op_b[MSB]) && (sum[MSB] != a_q[MSB]);
        shift_en = (cR ^ cL) & ~c0;
        shr      = cR & shift_en;
        shl      = cL & shift_en;
    end

    // Shifts act on the arithmetic result, giving a fused Booth step
    always_comb begin
        a_next = a_arith;
        if (c0) begin
            a_next = '0;
        end else if (c0_prim) begin
            a_next = INBUS;
        end else if (shr) begin
            a_next = {a_arith[MSB], a_arith[MSB:1]};
        end else if (shl) begin
            a_next = {a_arith[WIDTH-2:0], q_q[MSB]};
        end

        q_next = q_q;
        if (c1) begin
            q_next = INBUS;
        end else if (shr) begin
            q_next = {a_arith[0], q_q[MSB:1]};
        end else if (shl) begin
            q_next = {q_q[WIDTH-2:0], 1'b0};
        end
        if (c5 && !c1) begin
            q_next[0] = 1'b1;
        end

        q1_next = Q_1;
        if (c0) begin
            q1_next = 1'b0;
        end else if (shr) begin
            q1_next = q_q[0];
        end

        cnt_next = cnt_q;
        if (c0) begin
            cnt_next = '0;
        end else if (shift_en) begin
            cnt_next = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q    <= '0;
            q_q    <= '0;
            m_q    <= '0;
            Q_1    <= 1'b0;
            cnt_q  <= '0;
            OUTBUS <= '0;
            OVF    <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            a_q   <= a_next;
            q_q   <= q_next;
            Q_1   <= q1_next;
            cnt_q <= cnt_next;
            DONE  <= c8;
            if (c2) begin
                m_q <= INBUS;
            end
            if (c0) begin
                OVF <= 1'b0;
            end else if (arith_en) begin
                OVF <= ovf_next;
            end
            if (c7) begin
                OUTBUS <= q_q;
            end else if (c6) begin
                OUTBUS <= a_q;
            end
        end
    end

    assign Q0   = q_q[0];
    assign A7   = a_q[MSB];
    assign CNT7 = &cnt_q;

endmodule
